// File: rtl/mem_port_arbiter_if.sv
// Shared-memory arbitration bus: CPU and DMA requester channels plus the single memory port.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU-priority arbiter for the shared memory port with bounded DMA starvation; MEM_ARB_PERF_EN adds grant counters.
// Latency: req sampled in IDLE -> ack MEM_LAT+2 cycles later; requesters hold req stable until their ack.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              nrst,
   mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]       cpu_grant_cnt,
   output logic [15:0]       dma_grant_cnt
`endif
);
   localparam logic [3:0] LAT  = 4'(MEM_LAT);
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;   // 1 = DMA owns the current transaction
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wait_q, wait_d;
   logic [7:0]        starve_q, starve_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   logic any_req;
   logic dma_win;

   assign any_req = bus.cpu_req | bus.dma_req;
   // DMA wins when alone, or when the CPU has used up its starvation budget.
   assign dma_win = bus.dma_req & (~bus.cpu_req | (starve_q == SMAX));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_ACCESS;
         S_ACCESS: state_d = S_WAIT;
         S_WAIT:   if (wait_q == 4'd1) state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.cpu_ack   = 1'b0;
      bus.dma_ack   = 1'b0;
      case (state_q)
         S_ACCESS: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
         end
         S_ACK: begin
            bus.cpu_ack = ~grant_q;
            bus.dma_ack = grant_q;
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;

   always_comb begin
      grant_d     = grant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wait_d      = wait_q;
      starve_d    = starve_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d = dma_win;
               if (dma_win) begin
                  we_d     = bus.dma_we;
                  addr_d   = bus.dma_addr;
                  wdata_d  = bus.dma_wdata;
                  starve_d = 8'd0;
               end else begin
                  we_d    = bus.cpu_we;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
                  if (!bus.dma_req)         starve_d = 8'd0;
                  else if (starve_q != SMAX) starve_d = starve_q + 8'd1;
               end
            end
         end
         S_ACCESS: wait_d = LAT;
         S_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) begin
               if (grant_q) dma_rdata_d = bus.mem_rdata;
               else         cpu_rdata_d = bus.mem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         grant_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wait_q      <= 4'd0;
         starve_q    <= 8'd0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         grant_q     <= grant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [15:0] cpu_cnt_q, cpu_cnt_d;
   logic [15:0] dma_cnt_q, dma_cnt_d;

   always_comb begin
      cpu_cnt_d = cpu_cnt_q;
      dma_cnt_d = dma_cnt_q;
      if ((state_q == S_IDLE) && any_req) begin
         if (dma_win) begin
            if (dma_cnt_q != 16'hFFFF) dma_cnt_d = dma_cnt_q + 16'd1;
         end else begin
            if (cpu_cnt_q != 16'hFFFF) cpu_cnt_d = cpu_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cpu_cnt_q <= 16'd0;
         dma_cnt_q <= 16'd0;
      end else begin
         cpu_cnt_q <= cpu_cnt_d;
         dma_cnt_q <= dma_cnt_d;
      end
   end

   assign cpu_grant_cnt = cpu_cnt_q;
   assign dma_grant_cnt = dma_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1 with a small memory model,
// one at MEM_LAT=3 whose memory returns a cycle-stamped word to pin down the capture cycle.
module tb_mem_port_arbiter;
   logic clk  = 1'b0;
   logic nrst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata;} mexp_t;
   typedef struct {int cyc; logic dma; logic chk_rd; logic [31:0] rdata;} aexp_t;
   mexp_t mq[$];
   aexp_t aq[$];
   aexp_t aq3[$];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

`ifdef MEM_ARB_PERF_EN
   logic [15:0] cgc1, dgc1, cgc3, dgc3;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .nrst(nrst), .bus(b1.slave)
`ifdef MEM_ARB_PERF_EN
      , .cpu_grant_cnt(cgc1), .dma_grant_cnt(dgc1)
`endif
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .nrst(nrst), .bus(b3.slave)
`ifdef MEM_ARB_PERF_EN
      , .cpu_grant_cnt(cgc3), .dma_grant_cnt(dgc3)
`endif
   );

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Word i initially holds 0x2001_0001 + i, so 0x10 -> 0x2001_0005 and 0x20 -> 0x2001_0009.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h2001_0001 + 32'(i);
         b1.mem_rdata <= 32'd0;
      end else if (b1.mem_en) begin
         if (b1.mem_we) mem[b1.mem_addr[7:2]] <= b1.mem_wdata;
         else           b1.mem_rdata <= mem[b1.mem_addr[7:2]];
      end
   end

   always_comb b3.mem_rdata = {16'hA5A5, cyc[15:0]};

   always @(negedge clk) begin : mon1
      mexp_t m;
      aexp_t a;
      if (nrst) begin
         if (b1.mem_en) begin
            if (mq.size() == 0) chk("mem_en_unexpected", 64'(b1.mem_en), 64'd0);
            else begin
               m = mq.pop_front();
               chk("mem_en_cycle", 64'(cyc), 64'(m.cyc));
               chk("mem_we", 64'(b1.mem_we), 64'(m.we));
               chk("mem_addr", 64'(b1.mem_addr), 64'(m.addr));
               if (m.we) chk("mem_wdata", 64'(b1.mem_wdata), 64'(m.wdata));
            end
         end else if ({b1.mem_we, b1.mem_addr, b1.mem_wdata} != 65'd0) begin
            chk("mem_bus_idle", {b1.mem_addr, b1.mem_wdata}, 64'd0);
         end
         if (b1.cpu_ack || b1.dma_ack) begin
            if (aq.size() == 0) chk("ack_unexpected", {62'd0, b1.cpu_ack, b1.dma_ack}, 64'd0);
            else begin
               a = aq.pop_front();
               chk("ack_who", {62'd0, b1.cpu_ack, b1.dma_ack}, a.dma ? 64'd1 : 64'd2);
               chk("ack_cycle", 64'(cyc), 64'(a.cyc));
               if (a.chk_rd)
                  chk("ack_rdata", 64'(a.dma ? b1.dma_rdata : b1.cpu_rdata), 64'(a.rdata));
            end
         end
      end
   end

   always @(negedge clk) begin : mon3
      aexp_t a;
      if (nrst && (b3.cpu_ack || b3.dma_ack)) begin
         if (aq3.size() == 0) chk("lat3_ack_unexpected", {62'd0, b3.cpu_ack, b3.dma_ack}, 64'd0);
         else begin
            a = aq3.pop_front();
            chk("lat3_ack_who", {62'd0, b3.cpu_ack, b3.dma_ack}, a.dma ? 64'd1 : 64'd2);
            chk("lat3_ack_cycle", 64'(cyc), 64'(a.cyc));
            chk("lat3_rdata", 64'(a.dma ? b3.dma_rdata : b3.cpu_rdata), 64'(a.rdata));
         end
      end
   end

   task automatic do_txn(input bit dma, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_exp);
      int n;
      bit got;
      @(posedge clk); #1;
      if (dma) begin
         b1.dma_req = 1'b1; b1.dma_we = we; b1.dma_addr = addr; b1.dma_wdata = wdata;
      end else begin
         b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_addr = addr; b1.cpu_wdata = wdata;
      end
      n = cyc;
      mq.push_back('{n + 1, we, addr, wdata});
      aq.push_back('{n + 3, dma, !we, rd_exp});
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         got = dma ? b1.dma_ack : b1.cpu_ack;
      end
      b1.cpu_req = 1'b0;
      b1.dma_req = 1'b0;
      if (!got) chk("txn_ack_timeout", 64'(got), 64'd1);
   endtask

   // Both requesters held for n back-to-back reads; pat bit k = 1 means transaction k goes to DMA.
   task automatic burst(input int n, input logic [15:0] pat);
      int n0;
      @(posedge clk); #1;
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h10;
      b1.dma_req = 1'b1; b1.dma_we = 1'b0; b1.dma_addr = 32'h20;
      n0 = cyc;
      for (int k = 0; k < n; k++) begin
         mq.push_back('{n0 + 4*k + 1, 1'b0, pat[k] ? 32'h20 : 32'h10, 32'd0});
         aq.push_back('{n0 + 4*k + 3, pat[k], 1'b1, pat[k] ? 32'h2001_0009 : 32'h2001_0005});
      end
      repeat (4*n - 1) @(posedge clk);
      #1;
      b1.cpu_req = 1'b0;
      b1.dma_req = 1'b0;
   endtask

   initial begin
      int n;
      bit got;
      b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
      b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0;
      b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
      b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = 0; b3.dma_wdata = 0;
      #2 nrst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {58'd0, b1.cpu_ack, b1.dma_ack, b1.mem_en, b1.mem_we, b1.busy, b3.busy}, 64'd0);
      chk("rst_rdata", {b1.cpu_rdata, b1.dma_rdata}, 64'd0);
      chk("rst_bus", {b1.mem_addr, b1.mem_wdata}, 64'd0);
      nrst = 1'b1;

      do_txn(1'b0, 1'b0, 32'h10, 32'd0, 32'h2001_0005);

      // DMA write with busy window check
      @(posedge clk); #1;
      b1.dma_req = 1'b1; b1.dma_we = 1'b1; b1.dma_addr = 32'h40; b1.dma_wdata = 32'hDEAD_BEEF;
      n = cyc;
      mq.push_back('{n + 1, 1'b1, 32'h40, 32'hDEAD_BEEF});
      aq.push_back('{n + 3, 1'b1, 1'b0, 32'd0});
      @(negedge clk) chk("busy_N", 64'(b1.busy), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i == 3) b1.dma_req = 1'b0;
         @(negedge clk) chk($sformatf("busy_N+%0d", i), 64'(b1.busy), (i <= 3) ? 64'd1 : 64'd0);
      end

      do_txn(1'b0, 1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF);
      do_txn(1'b1, 1'b0, 32'h20, 32'd0, 32'h2001_0009);
      do_txn(1'b0, 1'b1, 32'h24, 32'h0BAD_F00D, 32'd0);
      do_txn(1'b1, 1'b0, 32'h24, 32'd0, 32'h0BAD_F00D);

      burst(10, 16'h0210);
      burst(3, 16'h0000);

      // Fourth CPU grant in a row, then reset in WAIT: no ack, outputs cleared, starvation state gone.
      @(posedge clk); #1;
      b1.cpu_req = 1'b1; b1.cpu_addr = 32'h10; b1.cpu_we = 1'b0;
      b1.dma_req = 1'b1; b1.dma_addr = 32'h20; b1.dma_we = 1'b0;
      n = cyc;
      mq.push_back('{n + 1, 1'b0, 32'h10, 32'd0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      nrst = 1'b0;
      #1;
      chk("wait_rst_ctl", {59'd0, b1.cpu_ack, b1.dma_ack, b1.mem_en, b1.mem_we, b1.busy}, 64'd0);
      chk("wait_rst_rdata", {b1.cpu_rdata, b1.dma_rdata}, 64'd0);
      chk("wait_rst_bus", {b1.mem_addr, b1.mem_wdata}, 64'd0);
      b1.cpu_req = 1'b0;
      b1.dma_req = 1'b0;
      @(negedge clk) nrst = 1'b1;
      repeat (6) @(posedge clk);
      burst(5, 16'h0010);

      // MEM_LAT=3 instance: rdata must be the word present 4 cycles after the sampling IDLE cycle.
      @(posedge clk); #1;
      b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h100;
      n = cyc;
      aq3.push_back('{n + 5, 1'b0, 1'b1, {16'hA5A5, 16'(n + 4)}});
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         got = b3.cpu_ack;
      end
      b3.cpu_req = 1'b0;
      if (!got) chk("lat3_ack_timeout", 64'(got), 64'd1);

      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("mem_queue_drained", 64'(mq.size()), 64'd0);
      chk("ack_queue_drained", 64'(aq.size()), 64'd0);
      chk("lat3_queue_drained", 64'(aq3.size()), 64'd0);
`ifdef MEM_ARB_PERF_EN
      chk("cpu_grant_cnt", 64'(cgc1), 64'd4);
      chk("dma_grant_cnt", 64'(dgc1), 64'd1);
      chk("lat3_cpu_grant_cnt", 64'(cgc3), 64'd1);
      chk("lat3_dma_grant_cnt", 64'(dgc3), 64'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
